alu_issue_ctrl: RTL and testbench

//  Issue/capture sequencer on the driving side of the ALU datapath interface (sr1, sr2, os, shift -> rd).

---
 rtl/alu_issue_ctrl_if.sv | 43 ++++
 rtl/alu_issue_ctrl.sv | 86 ++++++++
 tb/tb_alu_issue_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Handshake and ALU operand bus between decode, the issue sequencer, the ALU and write-back.
// master = issue sequencer side, slave = surrounding environment (decode, ALU, register file).
interface alu_issue_ctrl_if #(
  parameter int DW  = 32,
  parameter int SHW = 4,
  parameter int AW  = 5
);
  logic           instr_valid;
  logic           instr_ready;
  logic [2:0]     instr_op;
  logic [SHW-1:0] instr_shamt;
  logic [DW-1:0]  instr_rs1;
  logic [DW-1:0]  instr_rs2;
  logic [15:0]    instr_imm;
  logic           instr_use_imm;
  logic [AW-1:0]  instr_rd;

  logic [DW-1:0]  alu_sr1;
  logic [DW-1:0]  alu_sr2;
  logic [2:0]     alu_os;
  logic [SHW-1:0] alu_shift;
  logic [DW-1:0]  alu_rd;

  logic           wb_valid;
  logic           wb_ready;
  logic [AW-1:0]  wb_addr;
  logic [DW-1:0]  wb_data;
  logic           z_flag;

  modport master (
    input  instr_valid, instr_op, instr_shamt, instr_rs1, instr_rs2,
           instr_imm, instr_use_imm, instr_rd, alu_rd, wb_ready,
    output instr_ready, alu_sr1, alu_sr2, alu_os, alu_shift,
           wb_valid, wb_addr, wb_data, z_flag
  );

  modport slave (
    output instr_valid, instr_op, instr_shamt, instr_rs1, instr_rs2,
           instr_imm, instr_use_imm, instr_rd, alu_rd, wb_ready,
    input  instr_ready, alu_sr1, alu_sr2, alu_os, alu_shift,
           wb_valid, wb_addr, wb_data, z_flag
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Registers ALU operands per accepted instruction, captures alu_rd ALU_LAT cycles later, tracks zero flag.
// Latency: wb_valid ALU_LAT cycles after the accept edge; one instruction in flight, wb_ready may stall forever.
module alu_issue_ctrl #(
  parameter int DW      = 32,
  parameter int SHW     = 4,
  parameter int AW      = 5,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_ctrl_if.master  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       accept;
  logic       capture;
  logic       instr_ready_c;
  logic       wb_valid_c;

  always_comb begin
    state_nxt     = state;
    instr_ready_c = 1'b0;
    wb_valid_c    = 1'b0;
    capture       = 1'b0;
    case (state)
      IDLE: begin
        instr_ready_c = 1'b1;
        if (bus.instr_valid) state_nxt = EXEC;
      end
      EXEC: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = WB;
        end
      end
      WB: begin
        wb_valid_c = 1'b1;
        if (bus.wb_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept          = instr_ready_c && bus.instr_valid;
  assign bus.instr_ready = instr_ready_c;
  assign bus.wb_valid    = wb_valid_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      bus.alu_sr1   <= '0;
      bus.alu_sr2   <= '0;
      bus.alu_os    <= '0;
      bus.alu_shift <= '0;
      bus.wb_addr   <= '0;
      bus.wb_data   <= '0;
      bus.z_flag    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        bus.alu_sr1   <= bus.instr_rs1;
        bus.alu_sr2   <= bus.instr_use_imm ? {{(DW-16){bus.instr_imm[15]}}, bus.instr_imm}
                                           : bus.instr_rs2;
        bus.alu_os    <= bus.instr_op;
        bus.alu_shift <= bus.instr_shamt;
        bus.wb_addr   <= bus.instr_rd;
        cnt           <= 4'(ALU_LAT - 1);
      end else if (state == EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Zero flag only follows SUB results; every other op leaves it as it was.
      if (capture) begin
        bus.wb_data <= bus.alu_rd;
        if (bus.alu_os == 3'b111) bus.z_flag <= (bus.alu_rd == '0);
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one instance at ALU_LAT=1, one at ALU_LAT=4.
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst4 = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.DW(32), .SHW(4), .AW(5)) bus ();
  alu_issue_ctrl_if #(.DW(32), .SHW(4), .AW(5)) bus4 ();

  alu_issue_ctrl #(.DW(32), .SHW(4), .AW(5), .ALU_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_issue_ctrl #(.DW(32), .SHW(4), .AW(5), .ALU_LAT(4)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [3:0] sh);
    case (op)
      3'b000:  alu_f = a + b;
      3'b001:  alu_f = a << sh;
      3'b110:  alu_f = a | b;
      3'b111:  alu_f = a - b;
      default: alu_f = a & b;
    endcase
  endfunction

  assign bus.alu_rd  = alu_f(bus.alu_os, bus.alu_sr1, bus.alu_sr2, bus.alu_shift);
  assign bus4.alu_rd = alu_f(bus4.alu_os, bus4.alu_sr1, bus4.alu_sr2, bus4.alu_shift);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic use_imm, input logic [15:0] imm, input logic [4:0] rd);
    bit acc;
    acc = 1'b0;
    bus.instr_op      = op;
    bus.instr_rs1     = a;
    bus.instr_rs2     = b;
    bus.instr_use_imm = use_imm;
    bus.instr_imm     = imm;
    bus.instr_rd      = rd;
    bus.instr_shamt   = 4'd0;
    bus.instr_valid   = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = bus.instr_ready;
      tick();
    end
    bus.instr_valid = 1'b0;
    if (!acc) begin
      tests_run++;
      tests_failed++;
      $display("FAIL accept_timeout: instr_ready never high within 50 cycles");
    end
  endtask

  task automatic wait_wb();
    for (int i = 0; i < 50 && !bus.wb_valid; i++) tick();
    if (!bus.wb_valid) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wb_timeout: wb_valid never high within 50 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rst4 = 1'b1;
    bus.instr_valid = 1'b0;  bus.wb_ready = 1'b0;
    bus.instr_op = 3'd0;     bus.instr_shamt = 4'd0;
    bus.instr_rs1 = 32'd0;   bus.instr_rs2 = 32'd0;
    bus.instr_imm = 16'd0;   bus.instr_use_imm = 1'b0;  bus.instr_rd = 5'd0;
    bus4.instr_valid = 1'b0; bus4.wb_ready = 1'b0;
    bus4.instr_op = 3'd0;    bus4.instr_shamt = 4'd0;
    bus4.instr_rs1 = 32'd0;  bus4.instr_rs2 = 32'd0;
    bus4.instr_imm = 16'd0;  bus4.instr_use_imm = 1'b0; bus4.instr_rd = 5'd0;
    tick();
    tick();
    rst = 1'b0;
    rst4 = 1'b0;
    tests_run++; if (bus.instr_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", bus.instr_ready); end
    tests_run++; if (bus.wb_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_wb_valid: got %b want 0", bus.wb_valid); end
    tests_run++; if (bus.z_flag !== 1'b0) begin tests_failed++; $display("FAIL reset_z: got %b want 0", bus.z_flag); end
    tests_run++;
    if (bus.alu_sr1 !== 32'd0 || bus.alu_sr2 !== 32'd0 || bus.alu_os !== 3'd0 || bus.alu_shift !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_alu: sr1=%h sr2=%h os=%h sh=%h want all 0", bus.alu_sr1, bus.alu_sr2, bus.alu_os, bus.alu_shift);
    end
    tests_run++;
    if (bus.wb_data !== 32'd0 || bus.wb_addr !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_wb: data=%h addr=%h want 0", bus.wb_data, bus.wb_addr);
    end
  endtask

  task automatic test_add();
    bus.wb_ready = 1'b1;
    drive_op(3'b000, 32'd5, 32'd7, 1'b0, 16'd0, 5'd3);
    tests_run++;
    if (bus.alu_sr1 !== 32'd5 || bus.alu_sr2 !== 32'd7) begin
      tests_failed++;
      $display("FAIL add_operands: sr1=%0d sr2=%0d want 5 7", bus.alu_sr1, bus.alu_sr2);
    end
    tests_run++; if (bus.instr_ready !== 1'b0) begin tests_failed++; $display("FAIL add_busy: instr_ready=%b want 0", bus.instr_ready); end
    tests_run++; if (bus.wb_valid !== 1'b0) begin tests_failed++; $display("FAIL add_exec_wb: wb_valid=%b want 0", bus.wb_valid); end
    tick();
    tests_run++;
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'd12 || bus.wb_addr !== 5'd3) begin
      tests_failed++;
      $display("FAIL add_wb: valid=%b data=%0d addr=%0d want 1 12 3", bus.wb_valid, bus.wb_data, bus.wb_addr);
    end
    tick();
    tests_run++;
    if (bus.wb_valid !== 1'b0 || bus.instr_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL add_done: wb_valid=%b instr_ready=%b want 0 1", bus.wb_valid, bus.instr_ready);
    end
  endtask

  task automatic test_sub_zero();
    bus.wb_ready = 1'b1;
    drive_op(3'b111, 32'd9, 32'd9, 1'b0, 16'd0, 5'd4);
    wait_wb();
    tests_run++;
    if (bus.wb_data !== 32'd0 || bus.z_flag !== 1'b1) begin
      tests_failed++;
      $display("FAIL sub_eq: data=%0d z=%b want 0 1", bus.wb_data, bus.z_flag);
    end
    tick();
    drive_op(3'b111, 32'd9, 32'd4, 1'b0, 16'd0, 5'd4);
    wait_wb();
    tests_run++;
    if (bus.wb_data !== 32'd5 || bus.z_flag !== 1'b0) begin
      tests_failed++;
      $display("FAIL sub_ne: data=%0d z=%b want 5 0", bus.wb_data, bus.z_flag);
    end
    tick();
    drive_op(3'b110, 32'd0, 32'd0, 1'b0, 16'd0, 5'd6);
    wait_wb();
    tests_run++;
    if (bus.wb_data !== 32'd0 || bus.z_flag !== 1'b0) begin
      tests_failed++;
      $display("FAIL or_zero_keeps_z: data=%0d z=%b want 0 0", bus.wb_data, bus.z_flag);
    end
    tick();
  endtask

  task automatic test_imm();
    bus.wb_ready = 1'b1;
    drive_op(3'b111, 32'd3, 32'd3, 1'b0, 16'd0, 5'd1);
    wait_wb();
    tick();
    drive_op(3'b000, 32'd1, 32'd123, 1'b1, 16'hFFFF, 5'd2);
    tests_run++;
    if (bus.alu_sr2 !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL imm_sext: sr2=%h want ffffffff", bus.alu_sr2);
    end
    wait_wb();
    tests_run++;
    if (bus.wb_data !== 32'd0 || bus.z_flag !== 1'b1) begin
      tests_failed++;
      $display("FAIL imm_add: data=%h z=%b want 0 1", bus.wb_data, bus.z_flag);
    end
    tick();
    drive_op(3'b000, 32'd0, 32'd0, 1'b1, 16'h7FFF, 5'd2);
    tests_run++;
    if (bus.alu_sr2 !== 32'h0000_7FFF) begin
      tests_failed++;
      $display("FAIL imm_pos: sr2=%h want 00007fff", bus.alu_sr2);
    end
    wait_wb();
    tick();
  endtask

  task automatic test_backpressure();
    bus.wb_ready = 1'b0;
    drive_op(3'b000, 32'd2, 32'd3, 1'b0, 16'd0, 5'd7);
    bus.instr_op = 3'b111; bus.instr_rs1 = 32'd8; bus.instr_rs2 = 32'd1;
    bus.instr_use_imm = 1'b0; bus.instr_rd = 5'd9;
    bus.instr_valid = 1'b1;
    wait_wb();
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'd5 || bus.wb_addr !== 5'd7 ||
          bus.instr_ready !== 1'b0 || bus.alu_sr1 !== 32'd2) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%0d addr=%0d rdy=%b sr1=%0d want 1 5 7 0 2",
                 i, bus.wb_valid, bus.wb_data, bus.wb_addr, bus.instr_ready, bus.alu_sr1);
      end
      tick();
    end
    bus.wb_ready = 1'b1;
    tick();
    tests_run++;
    if (bus.wb_valid !== 1'b0 || bus.instr_ready !== 1'b1 || bus.alu_sr1 !== 32'd2) begin
      tests_failed++;
      $display("FAIL bp_release: valid=%b rdy=%b sr1=%0d want 0 1 2", bus.wb_valid, bus.instr_ready, bus.alu_sr1);
    end
    tick();
    bus.instr_valid = 1'b0;
    tests_run++;
    if (bus.alu_sr1 !== 32'd8 || bus.alu_os !== 3'b111) begin
      tests_failed++;
      $display("FAIL bp_second_accept: sr1=%0d os=%b want 8 111", bus.alu_sr1, bus.alu_os);
    end
    wait_wb();
    tests_run++;
    if (bus.wb_data !== 32'd7 || bus.wb_addr !== 5'd9) begin
      tests_failed++;
      $display("FAIL bp_second_wb: data=%0d addr=%0d want 7 9", bus.wb_data, bus.wb_addr);
    end
    tick();
  endtask

  task automatic test_reset_mid_exec();
    bit seen;
    bus4.wb_ready = 1'b1;
    bus4.instr_op = 3'b111; bus4.instr_rs1 = 32'd5; bus4.instr_rs2 = 32'd5; bus4.instr_rd = 5'd1;
    bus4.instr_valid = 1'b1;
    tick();
    bus4.instr_valid = 1'b0;
    // Accept edge just passed; with ALU_LAT=4 wb_valid must rise on the fourth edge after it.
    for (int i = 1; i <= 4; i++) begin
      tick();
      tests_run++;
      if (bus4.wb_valid !== (i == 4)) begin
        tests_failed++;
        $display("FAIL lat4_edge%0d: wb_valid=%b want %b", i, bus4.wb_valid, (i == 4));
      end
    end
    tests_run++;
    if (bus4.wb_data !== 32'd0 || bus4.z_flag !== 1'b1) begin
      tests_failed++;
      $display("FAIL lat4_result: data=%0d z=%b want 0 1", bus4.wb_data, bus4.z_flag);
    end
    tick();
    bus4.instr_rs1 = 32'd6; bus4.instr_rs2 = 32'd6;
    bus4.instr_valid = 1'b1;
    tick();
    bus4.instr_valid = 1'b0;
    tick();
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    tests_run++;
    if (bus4.instr_ready !== 1'b1 || bus4.wb_valid !== 1'b0 || bus4.z_flag !== 1'b0 || bus4.alu_sr1 !== 32'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_exec: rdy=%b valid=%b z=%b sr1=%0d want 1 0 0 0",
               bus4.instr_ready, bus4.wb_valid, bus4.z_flag, bus4.alu_sr1);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus4.wb_valid) seen = 1'b1;
      tick();
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_discard: wb_valid seen=%b want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_zero();
    test_imm();
    test_backpressure();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
